// File: rtl/vis_deframer.sv
// Reassembles LSB-first byte beats into {revis, imvis} visibility words and
// checks each frame for short words and a word count other than FRAME_LEN.
module vis_deframer #(
  parameter int ACCUM     = 32,
  parameter int FRAME_LEN = 8,
  parameter int FCOUNT    = 16
) (
  input  logic              clock,
  input  logic              areset_n,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic              s_tkeep,
  input  logic              s_tlast,
  input  logic [7:0]        s_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tfirst,
  output logic              m_tlast,
  output logic [ACCUM-1:0]  m_revis,
  output logic [ACCUM-1:0]  m_imvis,
  output logic              err_short_o,
  output logic              err_len_o,
  output logic [FCOUNT-1:0] frames_o
);

  localparam int BYTES = 2 * ACCUM / 8;
  localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int WW    = $clog2(FRAME_LEN + 1);
  localparam int SW    = 8 * (BYTES - 1);
  localparam logic [BW-1:0] BLAST = BW'(BYTES - 1);
  localparam logic [WW-1:0] WLEN  = WW'(FRAME_LEN);

  logic [BW-1:0] bcnt;
  logic [WW-1:0] wcnt;
  logic [WW-1:0] words;
  logic [SW-1:0] sreg;
  logic          first_flag;
  logic          over;
  logic          accept;
  logic          data_beat;
  logic          complete;
  logic          short_err;
  logic          drop_last;
  logic          frame_end;

  // Only the completing byte can stall; partial bytes never depend on the output.
  assign s_tready  = (bcnt != BLAST) || !m_tvalid || m_tready;
  assign accept    = s_tvalid && s_tready;
  assign data_beat = accept && s_tkeep;
  assign complete  = data_beat && (bcnt == BLAST);
  assign drop_last = accept && !s_tkeep && s_tlast && (bcnt == '0);
  assign short_err = (data_beat && s_tlast && (bcnt != BLAST)) ||
                     (accept && !s_tkeep && s_tlast && (bcnt != '0));
  assign frame_end = (complete && s_tlast) || drop_last;
  // Words in the frame including the one completing on this edge, if any.
  assign words     = wcnt + (complete ? WW'(1) : WW'(0));

  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      bcnt        <= '0;
      wcnt        <= '0;
      sreg        <= '0;
      first_flag  <= 1'b1;
      over        <= 1'b0;
      m_tvalid    <= 1'b0;
      m_tfirst    <= 1'b0;
      m_tlast     <= 1'b0;
      m_revis     <= '0;
      m_imvis     <= '0;
      err_short_o <= 1'b0;
      err_len_o   <= 1'b0;
      frames_o    <= '0;
    end else begin
      err_short_o <= 1'b0;
      err_len_o   <= 1'b0;

      if (m_tvalid && m_tready) m_tvalid <= 1'b0;

      if (data_beat && !complete) begin
        sreg <= SW'({s_tdata, sreg} >> 8);
        bcnt <= bcnt + BW'(1);
      end

      if (complete) begin
        bcnt                <= '0;
        m_tvalid            <= 1'b1;
        {m_revis, m_imvis}  <= {s_tdata, sreg};
        m_tfirst            <= first_flag;
        m_tlast             <= s_tlast;
        first_flag          <= s_tlast;
      end

      if (short_err) begin
        bcnt        <= '0;
        wcnt        <= '0;
        over        <= 1'b0;
        first_flag  <= 1'b1;
        err_short_o <= 1'b1;
      end else if (frame_end) begin
        // An overlong frame already reported its error; its tlast stays silent.
        if (!over) begin
          if (words == WLEN) frames_o  <= frames_o + FCOUNT'(1);
          else               err_len_o <= 1'b1;
        end
        wcnt       <= '0;
        over       <= 1'b0;
        first_flag <= 1'b1;
      end else if (complete) begin
        if (wcnt == WLEN) begin
          if (!over) begin
            err_len_o <= 1'b1;
            over      <= 1'b1;
          end
        end else begin
          wcnt <= wcnt + WW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_vis_deframer.sv
// Bench for vis_deframer: table of frame shapes driven byte by byte, expected
// words queued at drive time and compared as the DUT hands them off.
`timescale 1ns/1ps
module tb_vis_deframer;
  localparam int ACCUM     = 32;
  localparam int FRAME_LEN = 8;
  localparam int FCOUNT    = 3;
  localparam int BYTES     = 8;
  localparam int NCASE     = 10;

  logic              clock = 1'b0;
  logic              areset_n = 1'b0;
  logic              s_tvalid = 1'b0;
  logic              s_tready;
  logic              s_tkeep = 1'b0;
  logic              s_tlast = 1'b0;
  logic [7:0]        s_tdata = 8'h00;
  logic              m_tvalid;
  logic              m_tready = 1'b1;
  logic              m_tfirst;
  logic              m_tlast;
  logic [ACCUM-1:0]  m_revis;
  logic [ACCUM-1:0]  m_imvis;
  logic              err_short_o;
  logic              err_len_o;
  logic [FCOUNT-1:0] frames_o;

  always #5 clock = ~clock;

  vis_deframer #(.ACCUM(ACCUM), .FRAME_LEN(FRAME_LEN), .FCOUNT(FCOUNT)) dut (
    .clock(clock), .areset_n(areset_n),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tkeep(s_tkeep),
    .s_tlast(s_tlast), .s_tdata(s_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tfirst(m_tfirst),
    .m_tlast(m_tlast), .m_revis(m_revis), .m_imvis(m_imvis),
    .err_short_o(err_short_o), .err_len_o(err_len_o), .frames_o(frames_o)
  );

  typedef struct {
    logic [ACCUM-1:0] revis;
    logic [ACCUM-1:0] imvis;
    logic             first;
    logic             last;
  } exp_t;

  // nwords full words, then tail partial bytes; drop_last closes with a tkeep=0 tlast beat
  typedef struct {
    int nwords;
    int tail;
    bit drop_last;
    bit gaps;
    int rmode;
    int frames_inc;
    int n_short;
    int n_len;
  } case_t;

  exp_t  exp_q[$];
  case_t cases[NCASE];
  int    checks = 0;
  int    errors = 0;
  int    short_seen = 0;
  int    len_seen = 0;
  int    rmode = 0;
  int    rcyc = 0;
  int    beat_no = 0;
  int    exp_frames = 0;
  bit    exp_first = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] make_word(input int tag, input int w);
    logic [31:0] rev;
    logic [31:0] im;
    rev = 32'(w) | (32'(tag) << 8);
    im  = 32'h100 + 32'(w) + (32'(tag) << 16);
    return {rev, im};
  endfunction

  // downstream ready: 0 = always, 1 = one cycle on / three off, 2 = never
  initial begin
    forever begin
      @(posedge clock);
      #1;
      rcyc++;
      case (rmode)
        0:       m_tready = 1'b1;
        1:       m_tready = (rcyc % 4 == 0);
        default: m_tready = 1'b0;
      endcase
    end
  end

  // output monitor: pulse counting, hold stability, scoreboard pop
  initial begin
    logic              hold_prev;
    logic [2*ACCUM+2:0] snap;
    exp_t              e;
    hold_prev = 1'b0;
    snap = '0;
    forever begin
      @(negedge clock);
      if (err_short_o) short_seen++;
      if (err_len_o)   len_seen++;
      if (hold_prev && areset_n)
        check("hold", 64'({m_tvalid, m_tfirst, m_tlast, m_revis, m_imvis} != snap), 64'(0));
      if (m_tvalid && m_tready && areset_n) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got revis=%0h imvis=%0h required no output", m_revis, m_imvis);
        end else begin
          e = exp_q.pop_front();
          check("revis", 64'(m_revis), 64'(e.revis));
          check("imvis", 64'(m_imvis), 64'(e.imvis));
          check("tfirst", 64'(m_tfirst), 64'(e.first));
          check("tlast", 64'(m_tlast), 64'(e.last));
        end
      end
      hold_prev = m_tvalid && !m_tready && areset_n;
      snap = {m_tvalid, m_tfirst, m_tlast, m_revis, m_imvis};
    end
  end

  // entered and left at posedge+1; may_stall marks a beat presented at the completing lane
  task automatic send_beat(input logic [7:0] d, input logic keep, input logic last, input bit may_stall);
    int  waited;
    logic acc;
    waited = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tkeep  = keep;
    s_tlast  = last;
    forever begin
      @(negedge clock);
      acc = s_tready;
      if (!may_stall) check("s_tready", 64'(s_tready), 64'(1));
      @(posedge clock);
      #1;
      if (acc) break;
      waited++;
      if (waited > 50) begin
        checks++;
        errors++;
        $display("FAIL stall_timeout: s_tready low for %0d cycles, required high", waited);
        break;
      end
    end
    s_tvalid = 1'b0;
    s_tkeep  = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_data(input logic [7:0] d, input logic last, input int b, input bit gaps);
    if (gaps && (beat_no % 3 == 2)) begin
      send_beat(8'($urandom), 1'b0, 1'b0, b == BYTES - 1);
      beat_no++;
    end
    send_beat(d, 1'b1, last, b == BYTES - 1);
    beat_no++;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || m_tvalid) && t < 300) begin
      @(posedge clock);
      #1;
      t++;
    end
    if (t >= 300) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d words pending, required 0", exp_q.size());
    end
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic run_case(input case_t c, input int tag);
    logic [63:0] word;
    bit          lastw;
    exp_t        e;
    beat_no    = 0;
    short_seen = 0;
    len_seen   = 0;
    rmode      = c.rmode;
    for (int w = 0; w < c.nwords; w++) begin
      word  = make_word(tag, w);
      lastw = !c.drop_last && (c.tail == 0) && (w == c.nwords - 1);
      e.revis = word[63:32];
      e.imvis = word[31:0];
      e.first = exp_first;
      e.last  = lastw;
      exp_q.push_back(e);
      exp_first = 1'b0;
      for (int b = 0; b < BYTES; b++)
        send_data(word[8*b +: 8], lastw && (b == BYTES - 1), b, c.gaps);
    end
    word = make_word(tag, c.nwords);
    for (int b = 0; b < c.tail; b++)
      send_data(word[8*b +: 8], !c.drop_last && (b == c.tail - 1), b, c.gaps);
    if (c.drop_last) send_beat(8'hEE, 1'b0, 1'b1, c.tail == BYTES - 1);
    exp_first = 1'b1;
    wait_drain();
    exp_frames = (exp_frames + c.frames_inc) % (1 << FCOUNT);
    check("short_pulses", 64'(short_seen), 64'(c.n_short));
    check("len_pulses", 64'(len_seen), 64'(c.n_len));
    check("frames", 64'(frames_o), 64'(exp_frames));
    rmode = 0;
  endtask

  initial begin
    logic [63:0] word;
    exp_t        e;
    cases[0] = '{8, 0, 1'b0, 1'b0, 0, 1, 0, 0};  // clean frame
    cases[1] = '{8, 0, 1'b0, 1'b0, 1, 1, 0, 0};  // backpressure
    cases[2] = '{2, 6, 1'b0, 1'b0, 0, 0, 1, 0};  // tlast on byte 5 of word 2
    cases[3] = '{8, 0, 1'b0, 1'b0, 0, 1, 0, 0};  // recovery
    cases[4] = '{7, 0, 1'b0, 1'b0, 0, 0, 0, 1};  // short frame
    cases[5] = '{10, 0, 1'b0, 1'b0, 0, 0, 0, 1}; // overlong, single pulse
    cases[6] = '{8, 0, 1'b0, 1'b1, 0, 1, 0, 0};  // tkeep=0 gaps
    cases[7] = '{8, 0, 1'b1, 1'b0, 0, 1, 0, 0};  // dropped tlast closes frame
    cases[8] = '{2, 3, 1'b1, 1'b1, 1, 0, 1, 0};  // dropped tlast mid-word
    cases[9] = '{8, 0, 1'b0, 1'b1, 1, 1, 0, 0};  // gaps plus backpressure

    repeat (3) @(posedge clock);
    #1;
    check("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    check("rst_m_tfirst", 64'(m_tfirst), 64'(0));
    check("rst_m_tlast", 64'(m_tlast), 64'(0));
    check("rst_data", 64'({m_revis, m_imvis}), 64'(0));
    check("rst_errs", 64'({err_short_o, err_len_o}), 64'(0));
    check("rst_frames", 64'(frames_o), 64'(0));
    check("rst_s_tready", 64'(s_tready), 64'(1));
    @(negedge clock);
    areset_n = 1'b1;
    @(posedge clock);
    #1;

    // one-word frame: first output exactly one cycle after the completing byte
    short_seen = 0;
    len_seen   = 0;
    word = make_word(99, 0);
    e.revis = word[63:32];
    e.imvis = word[31:0];
    e.first = 1'b1;
    e.last  = 1'b1;
    exp_q.push_back(e);
    for (int b = 0; b < BYTES; b++) begin
      if (b == BYTES - 1) check("latency_pre", 64'(m_tvalid), 64'(0));
      send_beat(word[8*b +: 8], 1'b1, b == BYTES - 1, b == BYTES - 1);
    end
    check("latency_post", 64'(m_tvalid), 64'(1));
    wait_drain();
    check("one_word_len", 64'(len_seen), 64'(1));
    check("one_word_frames", 64'(frames_o), 64'(exp_frames));

    for (int i = 0; i < NCASE; i++) run_case(cases[i], i + 1);
    // carry the narrow frame counter past its wrap
    for (int i = 0; i < 3; i++) run_case(cases[0], 20 + i);

    // reset with a held output and a partial word in flight
    rmode = 2;
    word = make_word(50, 0);
    for (int b = 0; b < BYTES; b++) send_beat(word[8*b +: 8], 1'b1, 1'b0, 1'b0);
    for (int b = 0; b < 3; b++) send_beat(word[8*b +: 8], 1'b1, 1'b0, 1'b0);
    check("held_before_rst", 64'(m_tvalid), 64'(1));
    areset_n = 1'b0;
    #1;
    check("mid_rst_m_tvalid", 64'(m_tvalid), 64'(0));
    check("mid_rst_flags", 64'({m_tfirst, m_tlast, err_short_o, err_len_o}), 64'(0));
    check("mid_rst_data", 64'({m_revis, m_imvis}), 64'(0));
    check("mid_rst_frames", 64'(frames_o), 64'(0));
    check("mid_rst_s_tready", 64'(s_tready), 64'(1));
    exp_q.delete();
    exp_frames = 0;
    exp_first  = 1'b1;
    rmode = 0;
    repeat (2) @(negedge clock);
    areset_n = 1'b1;
    @(posedge clock);
    #1;
    run_case(cases[0], 60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
